// File: rtl/input_buffer_ctrl.sv
// Scheduler for the operand input buffer: one weight tile, then ACT_PER_W activation tiles, then the next weight.
// Latency: start->LOAD_W 1 cycle, capture->pe_start 1 cycle, accepted done->next state 1 cycle.
// Backpressure: waits in the load state with busy held high until the upstream valid arrives.
module input_buffer_ctrl #(
   parameter int ACT_PER_W = 4,
   parameter int AW        = (ACT_PER_W > 1) ? $clog2(ACT_PER_W) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [7:0]    i_num_w,
   input  logic          i_valid_W,
   output logic          o_ready_W,
   input  logic          i_valid_A,
   output logic          o_ready_A,
   output logic          o_busy_W,
   output logic          o_busy_A,
   output logic          o_pe_start,
   input  logic          i_pe_done,
   output logic [7:0]    o_w_idx,
   output logic [AW-1:0] o_a_idx,
   output logic          o_idle,
   output logic          o_done
);

   // Last legal activation index within one weight tile.
   localparam logic [AW-1:0] A_LAST = AW'(ACT_PER_W - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_W  = 3'd1,
      S_LOAD_A  = 3'd2,
      S_COMPUTE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [7:0]      num_w;
   logic [7:0]      w_idx;
   logic [AW-1:0]   a_idx;
   logic            pe_start_q;
   logic            done_q;
   logic            idle_q;

   logic            start_ok;
   logic            cap_w;
   logic            cap_a;
   logic            done_ok;
   logic            a_last;
   logic            w_last;
   logic [8:0]      w_next;

   // Handshake and progress qualifiers shared by the FSM and the index counters.
   always_comb begin
      start_ok = (state == S_IDLE) && i_start;
      cap_w    = (state == S_LOAD_W) && i_valid_W;
      cap_a    = (state == S_LOAD_A) && i_valid_A;
      // The pe_start cycle is the first COMPUTE cycle; a done there is stale.
      done_ok  = (state == S_COMPUTE) && !pe_start_q && i_pe_done;
      a_last   = (a_idx >= A_LAST);
      w_next   = {1'b0, w_idx} + 9'd1;
      // Widened compare so num_w never underflows.
      w_last   = (w_next >= {1'b0, num_w});
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               state_nxt = (i_num_w == 8'd0) ? S_DONE : S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (i_valid_W) begin
               state_nxt = S_LOAD_A;
            end
         end
         S_LOAD_A: begin
            if (i_valid_A) begin
               state_nxt = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            if (done_ok) begin
               if (!a_last) begin
                  state_nxt = S_LOAD_A;
               end else if (!w_last) begin
                  state_nxt = S_LOAD_W;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Combinational handshake outputs: ready by state, busy drops only on the capture edge.
   always_comb begin
      o_ready_W = (state == S_LOAD_W);
      o_ready_A = (state == S_LOAD_A);
      o_busy_W  = !cap_w;
      o_busy_A  = !cap_a;
   end

   // Job length and tile indices; cleared on start, advanced on accepted done, held otherwise.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         num_w <= 8'd0;
         w_idx <= 8'd0;
         a_idx <= '0;
      end else if (start_ok) begin
         num_w <= i_num_w;
         w_idx <= 8'd0;
         a_idx <= '0;
      end else if (done_ok) begin
         if (!a_last) begin
            a_idx <= a_idx + 1'b1;
         end else if (!w_last) begin
            a_idx <= '0;
            w_idx <= w_next[7:0];
         end
      end
   end

   // Registered status outputs, decoded from the state being entered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pe_start_q <= 1'b0;
         done_q     <= 1'b0;
         idle_q     <= 1'b1;
      end else begin
         pe_start_q <= (state_nxt == S_COMPUTE) && (state != S_COMPUTE);
         done_q     <= (state_nxt == S_DONE);
         idle_q     <= (state_nxt == S_IDLE);
      end
   end

   assign o_pe_start = pe_start_q;
   assign o_done     = done_q;
   assign o_idle     = idle_q;
   assign o_w_idx    = w_idx;
   assign o_a_idx    = a_idx;

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Randomized bench for input_buffer_ctrl against a transaction-count reference model.
// Inputs driven on the falling edge, outputs sampled 1 ns later.
// Handshake expectations derive from counts of W captures, A captures and accepted dones.
module tb_input_buffer_ctrl;

   localparam int ACT = 4;
   localparam int AW  = 2;

   logic          clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_start = 1'b0;
   logic [7:0]    i_num_w = 8'd0;
   logic          i_valid_W = 1'b0;
   logic          o_ready_W;
   logic          i_valid_A = 1'b0;
   logic          o_ready_A;
   logic          o_busy_W;
   logic          o_busy_A;
   logic          o_pe_start;
   logic          i_pe_done = 1'b0;
   logic [7:0]    o_w_idx;
   logic [AW-1:0] o_a_idx;
   logic          o_idle;
   logic          o_done;

   input_buffer_ctrl #(.ACT_PER_W(ACT), .AW(AW)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_num_w    (i_num_w),
      .i_valid_W  (i_valid_W),
      .o_ready_W  (o_ready_W),
      .i_valid_A  (i_valid_A),
      .o_ready_A  (o_ready_A),
      .o_busy_W   (o_busy_W),
      .o_busy_A   (o_busy_A),
      .o_pe_start (o_pe_start),
      .i_pe_done  (i_pe_done),
      .o_w_idx    (o_w_idx),
      .o_a_idx    (o_a_idx),
      .o_idle     (o_idle),
      .o_done     (o_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Stimulus knobs, percent probabilities.
   int p_vw, p_va, p_done, p_start;

   // Reference model: a job is described by counts of completed events.
   bit active    = 1'b0;
   bit done_due  = 1'b0;
   bit pulse_due = 1'b0;
   bit after_rst = 1'b0;
   int num       = 0;
   int k_w       = 0;
   int k_a       = 0;
   int k_done    = 0;
   int jobs_done = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic tick(input bit rst);
      bit rw, ra, comp, nxt_pulse;
      @(negedge clk);
      i_rst     = rst;
      i_start   = ($urandom_range(0, 99) < p_start);
      i_num_w   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
      i_valid_W = ($urandom_range(0, 99) < p_vw);
      i_valid_A = ($urandom_range(0, 99) < p_va);
      i_pe_done = ($urandom_range(0, 99) < p_done);
      #1;
      // W is wanted once every A of the previous W has been computed; A while the current W has A's left.
      rw   = active && !done_due && (k_a == k_done) && (k_a == k_w * ACT) && (k_w < num);
      ra   = active && !done_due && (k_a == k_done) && (k_a < k_w * ACT);
      comp = active && (k_a == k_done + 1);
      chk("ready_w",  32'(o_ready_W),  32'(rw));
      chk("ready_a",  32'(o_ready_A),  32'(ra));
      chk("busy_w",   32'(o_busy_W),   32'(!(rw && i_valid_W)));
      chk("busy_a",   32'(o_busy_A),   32'(!(ra && i_valid_A)));
      chk("pe_start", 32'(o_pe_start), 32'(pulse_due));
      chk("done",     32'(o_done),     32'(done_due));
      chk("idle",     32'(o_idle),     32'(!active));
      if (pulse_due) begin
         chk("w_idx_at_start", 32'(o_w_idx), 32'((k_a - 1) / ACT));
         chk("a_idx_at_start", 32'(o_a_idx), 32'((k_a - 1) % ACT));
      end
      if (done_due && num > 0) begin
         chk("w_idx_final", 32'(o_w_idx), 32'(num - 1));
         chk("a_idx_final", 32'(o_a_idx), 32'(ACT - 1));
      end
      if (after_rst) begin
         chk("w_idx_reset", 32'(o_w_idx), 32'd0);
         chk("a_idx_reset", 32'(o_a_idx), 32'd0);
      end
      // Advance the model to what the coming edge should do.
      nxt_pulse = ra && i_valid_A;
      if (rst) begin
         active    = 1'b0;
         done_due  = 1'b0;
         nxt_pulse = 1'b0;
         after_rst = 1'b1;
      end else begin
         after_rst = 1'b0;
         if (!active) begin
            if (i_start) begin
               active   = 1'b1;
               num      = int'(i_num_w);
               k_w      = 0;
               k_a      = 0;
               k_done   = 0;
               done_due = (num == 0);
            end
         end else if (done_due) begin
            active   = 1'b0;
            done_due = 1'b0;
            jobs_done++;
         end else begin
            if (rw && i_valid_W) k_w++;
            if (ra && i_valid_A) k_a++;
            if (comp && !pulse_due && i_pe_done) begin
               k_done++;
               if (k_done == num * ACT) done_due = 1'b1;
            end
         end
      end
      pulse_due = nxt_pulse;
   endtask

   task automatic run(input int cycles, input bit rst_mid);
      bit r;
      for (int c = 0; c < cycles; c++) begin
         // Directed mid-job reset while computing the pair (w=1, a=2).
         r = rst_mid && active && (k_a == ACT + 3) && (k_a == k_done + 1);
         tick(r);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      repeat (2) @(posedge clk);
      p_vw = 100; p_va = 100; p_done = 0; p_start = 0;
      tick(1'b1);
      tick(1'b0);
      // Free-flowing operands, moderate done rate.
      p_vw = 100; p_va = 100; p_done = 40; p_start = 30;
      run(300, 1'b0);
      // Upstream backpressure on both sides; starts arriving mid-job are ignored.
      p_vw = 25; p_va = 35; p_done = 50; p_start = 50;
      run(500, 1'b0);
      // Done held high: only the post-start cycle of each COMPUTE may advance.
      p_vw = 100; p_va = 100; p_done = 100; p_start = 40;
      run(300, 1'b0);
      // Mid-job resets followed by fresh jobs.
      p_vw = 80; p_va = 80; p_done = 60; p_start = 40;
      run(600, 1'b1);
      // Drain to idle.
      p_start = 0; p_vw = 100; p_va = 100; p_done = 100;
      run(80, 1'b0);
      chk("jobs_completed", 32'(jobs_done > 0), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
